// File: rtl/rx_stream_arbiter.sv
// Round-robin, packet-granular arbiter that merges NUM_SRC RX link streams onto one
// AXI-Stream master. Each burst is closed with TLAST and every beat is tagged with its source ID.

module rx_stream_arbiter_src (
    input  logic en,
    input  logic valid,
    input  logic done,
    input  logic sel,
    input  logic room,
    output logic req,
    output logic tready
);
    assign req    = en & valid & ~done;
    assign tready = sel & room;
endmodule

module rx_stream_arbiter #(
    parameter int NUM_SRC      = 4,
    parameter int DATA_W       = 16,
    parameter int IDLE_TIMEOUT = 100,
    parameter int MAX_BURST    = 1024,
    parameter int SRC_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC*DATA_W-1:0] S_AXIS_TDATA,
    input  logic [NUM_SRC-1:0]        S_AXIS_TVALID,
    output logic [NUM_SRC-1:0]        S_AXIS_TREADY,
    input  logic [NUM_SRC-1:0]        SRC_DONE,
    input  logic [NUM_SRC-1:0]        SRC_EN,
    output logic [DATA_W-1:0]         M_AXIS_TDATA,
    output logic                      M_AXIS_TVALID,
    input  logic                      M_AXIS_TREADY,
    output logic [DATA_W/8-1:0]       M_AXIS_TKEEP,
    output logic                      M_AXIS_TLAST,
    output logic [SRC_W-1:0]          M_AXIS_TUSER,
    output logic [SRC_W-1:0]          GRANT_ID,
    output logic                      BUSY,
    output logic                      PKT_DONE,
    output logic [31:0]               BURST_COUNT
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]             state;
    logic [SRC_W-1:0]       grant_id;
    logic [SRC_W-1:0]       rr_ptr;
    logic [1:0][DATA_W-1:0] fifo;
    logic [1:0]             fcnt;
    logic [31:0]            idle_cnt;
    logic [31:0]            acc_cnt;
    logic [31:0]            burst_cnt;
    logic                   pkt_done;

    logic [NUM_SRC-1:0]     req;
    logic [NUM_SRC-1:0]     sel;
    logic                   granted;
    logic                   room;
    logic                   in_acc;
    logic                   m_valid;
    logic                   out_hs;
    logic                   end_cond;
    logic                   any_req;
    logic [SRC_W-1:0]       winner;
    logic [SRC_W:0]         cand;
    logic [DATA_W-1:0]      in_data;
    logic [1:0]             fcnt_nxt;

    assign granted = (state == ST_GRANT);
    // Stop accepting once MAX_BURST beats are in so the closing cycle cannot add one more.
    assign room    = (fcnt != 2'd2) && (acc_cnt != 32'(MAX_BURST));

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign sel[i] = granted && (grant_id == SRC_W'(i));
        rx_stream_arbiter_src u_src (
            .en     (SRC_EN[i]),
            .valid  (S_AXIS_TVALID[i]),
            .done   (SRC_DONE[i]),
            .sel    (sel[i]),
            .room   (room),
            .req    (req[i]),
            .tready (S_AXIS_TREADY[i])
        );
    end

    assign in_acc = |(S_AXIS_TVALID & S_AXIS_TREADY);

    always_comb begin
        in_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_id == SRC_W'(i)) in_data = S_AXIS_TDATA[i*DATA_W +: DATA_W];
        end
    end

    // First requester after rr_ptr, wrapping; rr_ptr itself is checked last.
    always_comb begin
        any_req = 1'b0;
        winner  = rr_ptr;
        cand    = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = {1'b0, rr_ptr} + (SRC_W+1)'(k);
            if (cand >= (SRC_W+1)'(NUM_SRC)) cand = cand - (SRC_W+1)'(NUM_SRC);
            if (!any_req && req[cand[SRC_W-1:0]]) begin
                any_req = 1'b1;
                winner  = cand[SRC_W-1:0];
            end
        end
    end

    // While granted, the head is shown only with a second beat behind it, so it cannot be last.
    assign m_valid  = (granted && fcnt == 2'd2) || (state == ST_FLUSH && fcnt != 2'd0);
    assign out_hs   = m_valid && M_AXIS_TREADY;
    assign fcnt_nxt = fcnt + {1'b0, in_acc} - {1'b0, out_hs};
    assign end_cond = granted && (SRC_DONE[grant_id] || !SRC_EN[grant_id] ||
                                  idle_cnt == 32'(IDLE_TIMEOUT) ||
                                  acc_cnt == 32'(MAX_BURST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo <= '0;
            fcnt <= 2'd0;
        end else begin
            fcnt <= fcnt_nxt;
            case ({in_acc, out_hs})
                2'b10: fifo[fcnt[0]] <= in_data;
                2'b01: fifo[0] <= fifo[1];
                2'b11: begin
                    fifo[0] <= (fcnt == 2'd1) ? in_data : fifo[1];
                    fifo[1] <= in_data;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            grant_id  <= '0;
            rr_ptr    <= SRC_W'(NUM_SRC - 1);
            idle_cnt  <= '0;
            acc_cnt   <= '0;
            burst_cnt <= '0;
            pkt_done  <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            if (out_hs) burst_cnt <= burst_cnt + 32'd1;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant_id  <= winner;
                        rr_ptr    <= winner;
                        idle_cnt  <= '0;
                        acc_cnt   <= '0;
                        burst_cnt <= '0;
                        state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    idle_cnt <= in_acc ? 32'd0 : idle_cnt + 32'd1;
                    if (in_acc) acc_cnt <= acc_cnt + 32'd1;
                    if (end_cond) state <= (fcnt_nxt == 2'd0) ? ST_IDLE : ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (fcnt == 2'd0) begin
                        state <= ST_IDLE;
                    end else if (out_hs && fcnt == 2'd1) begin
                        state    <= ST_IDLE;
                        pkt_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign M_AXIS_TDATA  = fifo[0];
    assign M_AXIS_TVALID = m_valid;
    assign M_AXIS_TKEEP  = '1;
    assign M_AXIS_TLAST  = (state == ST_FLUSH) && (fcnt == 2'd1);
    assign M_AXIS_TUSER  = grant_id;
    assign GRANT_ID      = grant_id;
    assign BUSY          = (state != ST_IDLE);
    assign PKT_DONE      = pkt_done;
    assign BURST_COUNT   = burst_cnt;
endmodule
